// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment loop-back monitor.
// Glyphs are active-high, bit order g..a.
package seven_seg_pkg;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam int         DP_BIT    = 7;
endpackage

// File: rtl/seven_to_hex.sv
// Inverse of the display path's hex-to-segment encoder.
// Unknown patterns (including all-dark) report hex 0 with match low.
module seven_to_hex
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       match
);
    always_comb begin
        hex   = 4'h0;
        match = 1'b1;
        case (seg)
            SEG_0:   hex = 4'h0;
            SEG_1:   hex = 4'h1;
            SEG_2:   hex = 4'h2;
            SEG_3:   hex = 4'h3;
            SEG_4:   hex = 4'h4;
            SEG_5:   hex = 4'h5;
            SEG_6:   hex = 4'h6;
            SEG_7:   hex = 4'h7;
            SEG_8:   hex = 4'h8;
            SEG_9:   hex = 4'h9;
            SEG_A:   hex = 4'hA;
            SEG_B:   hex = 4'hB;
            SEG_C:   hex = 4'hC;
            SEG_D:   hex = 4'hD;
            SEG_E:   hex = 4'hE;
            SEG_F:   hex = 4'hF;
            default: match = 1'b0;
        endcase
    end
endmodule

// File: rtl/seven_seg_capture.sv
// Loop-back monitor: recovers digits from a multiplexed active-low 7-seg bus.
// Define SEVEN_SEG_CAPTURE_DP_EN to decode the decimal point; otherwise dp is 0.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:0]              seven,
    input  logic [NUM_DIGITS-1:0]   an,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   inv,
    output logic                    frame_err,
    output logic                    frame_valid,
    input  logic                    frame_ready
);
    localparam int SW = NUM_DIGITS + 8;

    logic [7:0]              seven_eff;
    logic                    dp_val;
    logic [SW-1:0]           cur, s_q;
    logic [7:0]              cnt;
    logic                    stable, capture, slot_wr, transfer;
    logic [3:0]              low_cnt;
    logic [3:0]              hex_val;
    logic                    match;
    logic [NUM_DIGITS-1:0]   mask, mask_next;
    logic                    sh_err, err_next;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp, sh_inv;

`ifdef SEVEN_SEG_CAPTURE_DP_EN
    assign seven_eff = seven;
    assign dp_val    = ~seven_eff[DP_BIT];
`else
    // DP line is forced inactive so it never disturbs stability
    logic unused_dp_line;
    assign unused_dp_line = seven[DP_BIT];
    assign seven_eff      = {1'b1, seven[6:0]};
    assign dp_val         = 1'b0;
`endif

    assign cur     = {an, seven_eff};
    assign stable  = (cur == s_q);
    assign capture = stable && (cnt == 8'(STABLE_CYCLES - 1));

    always_comb begin
        low_cnt = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!an[i]) low_cnt = low_cnt + 4'd1;
    end

    assign slot_wr  = capture && (low_cnt == 4'd1);
    assign transfer = (&mask) && (!frame_valid || frame_ready);

    seven_to_hex u_dec (
        .seg   (~seven_eff[6:0]),
        .hex   (hex_val),
        .match (match)
    );

    // A capture on the transfer edge belongs to the next frame
    always_comb begin
        mask_next = transfer ? '0 : mask;
        err_next  = transfer ? 1'b0 : sh_err;
        if (slot_wr)
            mask_next = mask_next | ~an;
        if (capture && (low_cnt > 4'd1))
            err_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q         <= '1;
            cnt         <= '0;
            mask        <= '0;
            sh_err      <= 1'b0;
            sh_digits   <= '0;
            sh_dp       <= '0;
            sh_inv      <= '0;
            digits      <= '0;
            dp          <= '0;
            inv         <= '0;
            frame_err   <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            s_q <= cur;
            if (!stable)
                cnt <= '0;
            else if (cnt < 8'(STABLE_CYCLES))
                cnt <= cnt + 8'd1;
            mask   <= mask_next;
            sh_err <= err_next;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (slot_wr && !an[k]) begin
                    sh_digits[4*k +: 4] <= hex_val;
                    sh_inv[k]           <= ~match;
                    sh_dp[k]            <= dp_val;
                end
            end
            if (transfer) begin
                digits      <= sh_digits;
                dp          <= sh_dp;
                inv         <= sh_inv;
                frame_err   <= sh_err;
                frame_valid <= 1'b1;
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture with NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_seven_seg_capture;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seven;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  dp, inv;
    logic        frame_err, frame_valid, frame_ready;
    int          total = 0;
    int          bad   = 0;

    localparam logic [6:0] GLY [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    always #5 clk = ~clk;

    seven_seg_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seven       (seven),
        .an          (an),
        .digits      (digits),
        .dp          (dp),
        .inv         (inv),
        .frame_err   (frame_err),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready)
    );

    function automatic logic [7:0] enc(input int v, input bit p);
        return {~p, ~GLY[v]};
    endfunction

    // Called at a negedge; holds the bus over n rising edges, returns at a negedge
    task automatic show(input logic [3:0] a, input logic [7:0] s, input int n);
        an = a; seven = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan4(input logic [7:0] s0, s1, s2, s3);
        show(4'b1110, s0, 5);
        show(4'b1101, s1, 5);
        show(4'b1011, s2, 5);
        show(4'b0111, s3, 5);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; an = 4'hF; seven = 8'hFF; frame_ready = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({digits, dp, inv, frame_err, frame_valid} !== 26'd0) begin
            bad++; $display("FAIL reset_out: got %h want 0", {digits, dp, inv, frame_err, frame_valid});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if ({digits, dp, inv, frame_err, frame_valid} !== 26'd0) begin
                bad++; $display("FAIL idle_out cyc %0d: got %h want 0", i, {digits, dp, inv, frame_err, frame_valid});
            end
        end
    endtask

    task automatic test_scan();
        frame_ready = 1'b1;
        scan4(enc(1, 0), enc(2, 0), enc(3, 0), enc(4, 0));
        total++;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL scan_early_valid: got %b want 0", frame_valid); end
        show(4'hF, 8'hFF, 1);
        total++;
        if (frame_valid !== 1'b1) begin bad++; $display("FAIL scan_valid: got %b want 1", frame_valid); end
        total++;
        if ({digits, dp, inv, frame_err} !== {16'h4321, 4'h0, 4'h0, 1'b0}) begin
            bad++; $display("FAIL scan_data: got %h/%b/%b/%b want 4321/0000/0000/0", digits, dp, inv, frame_err);
        end
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL scan_pulse: got %b want 0", frame_valid); end
    endtask

    task automatic test_dp();
        logic [3:0] exp_dp;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
        exp_dp = 4'b0001;
`else
        exp_dp = 4'b0000;
`endif
        scan4(~8'hF9, enc(12, 0), enc(12, 0), enc(12, 0));
        show(4'hF, 8'hFF, 1);
        total++;
        if (frame_valid !== 1'b1 || digits !== 16'hCCCE) begin
            bad++; $display("FAIL dp_digits: got v=%b %h want v=1 ccce", frame_valid, digits);
        end
        total++;
        if (dp !== exp_dp || inv !== 4'h0) begin
            bad++; $display("FAIL dp_bits: got dp=%b inv=%b want dp=%b inv=0000", dp, inv, exp_dp);
        end
        @(negedge clk);
    endtask

    task automatic test_inv_glitch();
        show(4'b1110, enc(0, 0), 5);
        show(4'b1101, enc(5, 0), 5);
        show(4'b1101, 8'h00, 3);
        show(4'b1011, 8'hB6, 5);
        show(4'b0111, enc(9, 0), 5);
        show(4'hF, 8'hFF, 1);
        total++;
        if (frame_valid !== 1'b1 || digits !== 16'h9050) begin
            bad++; $display("FAIL glitch_digits: got v=%b %h want v=1 9050", frame_valid, digits);
        end
        total++;
        if (inv !== 4'b0100 || dp !== 4'b0000 || frame_err !== 1'b0) begin
            bad++; $display("FAIL glitch_inv: got inv=%b dp=%b err=%b want 0100/0000/0", inv, dp, frame_err);
        end
        @(negedge clk);
    endtask

    task automatic test_frame_err();
        show(4'b1110, enc(10, 0), 5);
        show(4'b1101, enc(11, 0), 5);
        show(4'b1100, enc(8, 0), 5);
        show(4'b1011, enc(12, 0), 5);
        show(4'b0111, enc(13, 0), 5);
        show(4'hF, 8'hFF, 1);
        total++;
        if (frame_valid !== 1'b1 || frame_err !== 1'b1 || digits !== 16'hDCBA) begin
            bad++; $display("FAIL err_frame: got v=%b err=%b %h want 1/1/dcba", frame_valid, frame_err, digits);
        end
        @(negedge clk);
        scan4(enc(0, 0), enc(1, 0), enc(2, 0), enc(3, 0));
        show(4'hF, 8'hFF, 1);
        total++;
        if (frame_valid !== 1'b1 || frame_err !== 1'b0 || digits !== 16'h3210) begin
            bad++; $display("FAIL err_cleared: got v=%b err=%b %h want 1/0/3210", frame_valid, frame_err, digits);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        frame_ready = 1'b0;
        scan4(enc(1, 0), enc(2, 0), enc(3, 0), enc(4, 0));
        show(4'hF, 8'hFF, 1);
        total++;
        if (frame_valid !== 1'b1 || digits !== 16'h4321) begin
            bad++; $display("FAIL bp_first: got v=%b %h want 1/4321", frame_valid, digits);
        end
        scan4(enc(5, 0), enc(6, 0), enc(7, 0), enc(8, 0));
        total++;
        if (frame_valid !== 1'b1 || digits !== 16'h4321) begin
            bad++; $display("FAIL bp_hold2: got v=%b %h want 1/4321", frame_valid, digits);
        end
        scan4(enc(9, 0), enc(10, 0), enc(11, 0), enc(12, 0));
        total++;
        if (frame_valid !== 1'b1 || digits !== 16'h4321) begin
            bad++; $display("FAIL bp_hold3: got v=%b %h want 1/4321", frame_valid, digits);
        end
        frame_ready = 1'b1;
        show(4'hF, 8'hFF, 1);
        total++;
        if (frame_valid !== 1'b1 || digits !== 16'hCBA9) begin
            bad++; $display("FAIL bp_latest: got v=%b %h want 1/cba9", frame_valid, digits);
        end
        @(negedge clk);
        total++;
        if (frame_valid !== 1'b0) begin bad++; $display("FAIL bp_drop: got %b want 0", frame_valid); end
    endtask

    task automatic test_async_reset();
        show(4'b1110, enc(7, 0), 2);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({digits, dp, inv, frame_err, frame_valid} !== 26'd0) begin
            bad++; $display("FAIL async_reset: got %h want 0", {digits, dp, inv, frame_err, frame_valid});
        end
        @(negedge clk);
        rst_n = 1'b1;
        show(4'hF, 8'hFF, 3);
    endtask

    initial begin
        test_reset();
        test_scan();
        test_dp();
        test_inv_glitch();
        test_frame_err();
        test_backpressure();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
